// File: rtl/sn_ring_stop.sv
// Per-tile stop on the signaling ring: registered forwarding, local workload FIFO,
// broadcast delivery, outstanding-work tracking and SYNC-driven ack/done pulses.
module sn_ring_stop #(
    parameter int unsigned TILE_WIDTH  = 4,
    parameter int unsigned ADDR_WIDTH  = 64,
    parameter int unsigned WL_LEN_BITS = 32,
    parameter int unsigned TILE_ID     = 0,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned MAX_OUT     = 8,
    parameter int unsigned BCAST_EN    = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    input  logic                           in_op,
    input  logic [TILE_WIDTH-1:0]          in_tile,
    input  logic [ADDR_WIDTH-1:0]          in_addr,
    input  logic [WL_LEN_BITS-1:0]         in_len,
    output logic                           in_ready,
    output logic                           out_valid,
    output logic                           out_op,
    output logic [TILE_WIDTH-1:0]          out_tile,
    output logic [ADDR_WIDTH-1:0]          out_addr,
    output logic [WL_LEN_BITS-1:0]         out_len,
    input  logic                           out_ready,
    output logic                           wl_valid,
    output logic [ADDR_WIDTH-1:0]          wl_addr,
    output logic [WL_LEN_BITS-1:0]         wl_len,
    input  logic                           wl_ready,
    input  logic                           wl_done,
    output logic                           ack,
    output logic                           done,
    output logic                           err,
    output logic [$clog2(MAX_OUT+1)-1:0]   outstanding
);

    localparam int unsigned CW = $clog2(MAX_OUT + 1);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);

    typedef enum logic {IDLE, PEND} sync_state_t;

    sync_state_t              sync_state;
    logic                     is_local, is_bcast, is_fwd;
    logic                     fwd_ok, work_ok, loc_ok;
    logic                     accept, fwd_acc, loc_acc, push, pop, sync_acc;
    logic                     fifo_full, fifo_empty;
    logic [PW:0]              wr_ptr, rd_ptr, fifo_cnt;
    logic [CW-1:0]            cnt_next;
    logic                     err_set;
    logic [ADDR_WIDTH-1:0]    addr_mem [FIFO_DEPTH];
    logic [WL_LEN_BITS-1:0]   len_mem  [FIFO_DEPTH];

    always_comb begin
        is_local = (in_tile == TILE_WIDTH'(TILE_ID));
        is_bcast = (BCAST_EN != 0) && (in_tile == '1);
        is_fwd   = !is_local && !is_bcast;

        fifo_cnt   = wr_ptr - rd_ptr;
        fifo_empty = (wr_ptr == rd_ptr);
        fifo_full  = (fifo_cnt == (PW+1)'(FIFO_DEPTH));
        pop        = !fifo_empty && wl_ready;

        // A same-edge pop frees a slot, so a full FIFO can still take a push.
        fwd_ok  = !out_valid || out_ready;
        work_ok = (!fifo_full || pop) && (outstanding < CW'(MAX_OUT));
        loc_ok  = in_op ? 1'b1 : work_ok;

        if (is_bcast)      in_ready = fwd_ok && loc_ok;
        else if (is_local) in_ready = loc_ok;
        else               in_ready = fwd_ok;

        accept   = in_valid && in_ready;
        fwd_acc  = accept && (is_fwd || is_bcast);
        loc_acc  = accept && (is_local || is_bcast);
        push     = loc_acc && !in_op;
        sync_acc = loc_acc && in_op;

        cnt_next = outstanding;
        err_set  = 1'b0;
        if (push && !wl_done) begin
            cnt_next = outstanding + CW'(1);
        end else if (!push && wl_done) begin
            if (outstanding != '0) cnt_next = outstanding - CW'(1);
            else                   err_set  = 1'b1;
        end
    end

    assign wl_valid = !fifo_empty;
    assign wl_addr  = addr_mem[rd_ptr[PW-1:0]];
    assign wl_len   = len_mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_op    <= 1'b0;
            out_tile  <= '0;
            out_addr  <= '0;
            out_len   <= '0;
        end else if (fwd_acc) begin
            out_valid <= 1'b1;
            out_op    <= in_op;
            out_tile  <= in_tile;
            out_addr  <= in_addr;
            out_len   <= in_len;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                addr_mem[i] <= '0;
                len_mem[i]  <= '0;
            end
        end else begin
            if (push) begin
                addr_mem[wr_ptr[PW-1:0]] <= in_addr;
                len_mem[wr_ptr[PW-1:0]]  <= in_len;
                wr_ptr <= wr_ptr + (PW+1)'(1);
            end
            if (pop) rd_ptr <= rd_ptr + (PW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
            ack         <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            sync_state  <= IDLE;
        end else begin
            outstanding <= cnt_next;
            ack         <= loc_acc;
            if (err_set) err <= 1'b1;
            // Pending SYNCs merge: one done once the count drains to zero.
            if ((sync_acc || sync_state == PEND) && cnt_next == '0) begin
                done       <= 1'b1;
                sync_state <= IDLE;
            end else begin
                done <= 1'b0;
                if (sync_acc) sync_state <= PEND;
            end
        end
    end

endmodule
